// File: rtl/tone_sched_pkg.sv
// Shared state type, default note-divide table and lowest-set-bit helper for tone_scheduler.
package tone_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    PLAY   = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_KEYS  = 8;
  localparam int unsigned DEFAULT_DIV_W = 32;
  localparam int unsigned PRIO_MAX      = 64;

  // Toggle-divider half-period counts for C4..C5 from a 50 MHz clk.
  localparam logic [DEFAULT_DIV_W-1:0] DEFAULT_DIV [DEFAULT_KEYS] = '{
    32'd95556, 32'd85131, 32'd75843, 32'd71586,
    32'd63776, 32'd56818, 32'd50619, 32'd47778
  };

  function automatic logic [DEFAULT_DIV_W-1:0] default_div(input int unsigned idx);
    logic [DEFAULT_DIV_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DEFAULT_KEYS; i++) begin
      if (i == idx) r = DEFAULT_DIV[3'(i)];
    end
    return r;
  endfunction

  // Index 0 has the highest priority; returns 0 for an empty vector.
  function automatic int unsigned lowest_set(input logic [PRIO_MAX-1:0] vec);
    int unsigned r;
    r = 0;
    for (int i = PRIO_MAX - 1; i >= 0; i--) begin
      if (vec[6'(i)]) r = 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/tone_sched_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins, valid when any bit is set.
module tone_sched_prio_enc
  import tone_sched_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 8,
  parameter int unsigned KEY_W    = 3
) (
  input  logic [NUM_KEYS-1:0] req,
  output logic [KEY_W-1:0]    idx_c,
  output logic                valid_c
);

  always_comb begin
    valid_c = |req;
    idx_c   = KEY_W'(lowest_set(PRIO_MAX'(req)));
  end

endmodule

// File: rtl/tone_scheduler.sv
// Key arbitration and note sequencing for the shared tone clock divider.
// Build option TONE_SCHED_OCTAVE_EN adds oct_up, a right-shift applied to every table load.
module tone_scheduler
  import tone_sched_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 8,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned HOLD_CYCLES = 50000,
  parameter int unsigned KEY_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_req,
  input  logic                div_tick,
  input  logic                cfg_we,
  input  logic [KEY_W-1:0]    cfg_addr,
  input  logic [DIV_W-1:0]    cfg_data,
`ifdef TONE_SCHED_OCTAVE_EN
  input  logic [1:0]          oct_up,
`endif
  output logic [DIV_W-1:0]    div_value,
  output logic                div_rst,
  output logic                tone_active,
  output logic [KEY_W-1:0]    cur_key
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_value_d;
  logic               div_rst_d, tone_active_d;
  logic [KEY_W-1:0]   cur_key_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               tick_q;
  logic               tick_edge;
  logic               load;
  logic               retune;
  logic [KEY_W-1:0]   cand_idx;
  logic               cand_valid;
  logic [DIV_W-1:0]   load_value;
  logic [DIV_W-1:0]   div_table [NUM_KEYS];
`ifdef TONE_SCHED_OCTAVE_EN
  logic [1:0]         oct_q, oct_d;
`endif

  tone_sched_prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W)
  ) u_prio (
    .req     (key_req),
    .idx_c   (cand_idx),
    .valid_c (cand_valid)
  );

  // Writable divide table; a load in the same cycle as a write reads the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        div_table[KEY_W'(i)] <= DIV_W'(default_div(i));
      end
    end else if (cfg_we && (32'(cfg_addr) < NUM_KEYS)) begin
      div_table[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    tick_edge = (div_tick != tick_q);
`ifdef TONE_SCHED_OCTAVE_EN
    load_value = div_table[cand_idx] >> oct_up;
    retune     = (cand_idx != cur_key) || (oct_up != oct_q);
`else
    load_value = div_table[cand_idx];
    retune     = (cand_idx != cur_key);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_value   <= '0;
      div_rst     <= 1'b1;
      tone_active <= 1'b0;
      cur_key     <= '0;
      hold_q      <= '0;
      tick_q      <= 1'b0;
`ifdef TONE_SCHED_OCTAVE_EN
      oct_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_value   <= div_value_d;
      div_rst     <= div_rst_d;
      tone_active <= tone_active_d;
      cur_key     <= cur_key_d;
      hold_q      <= hold_d;
      tick_q      <= div_tick;
`ifdef TONE_SCHED_OCTAVE_EN
      oct_q       <= oct_d;
`endif
    end
  end

  // div_value only moves on a load: from IDLE (divider held) or on a tick edge in SWITCH.
  always_comb begin
    state_d       = state_q;
    div_value_d   = div_value;
    div_rst_d     = div_rst;
    tone_active_d = tone_active;
    cur_key_d     = cur_key;
    hold_d        = hold_q;
    load          = 1'b0;
`ifdef TONE_SCHED_OCTAVE_EN
    oct_d         = oct_q;
`endif

    unique case (state_q)
      IDLE: begin
        div_rst_d     = 1'b1;
        tone_active_d = 1'b0;
        if (cand_valid) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        div_rst_d     = 1'b0;
        tone_active_d = 1'b1;
        hold_d        = HOLD_LOAD;
        state_d       = PLAY;
      end
      PLAY: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (!cand_valid) begin
          div_rst_d     = 1'b1;
          tone_active_d = 1'b0;
          state_d       = IDLE;
        end else if (retune) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        if (!cand_valid) begin
          div_rst_d     = 1'b1;
          tone_active_d = 1'b0;
          state_d       = IDLE;
        end else if (!retune) begin
          state_d = PLAY;
        end else if (tick_edge) begin
          load    = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      cur_key_d   = cand_idx;
      div_value_d = load_value;
`ifdef TONE_SCHED_OCTAVE_EN
      oct_d       = oct_up;
`endif
    end
  end

endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
- Controls the shared tone clock divider.
- Arbitrates NUM_KEYS key requests down to one active note and looks up that note's divide value in a writable table.
- Sequences the divider's div_value and reset so notes start cleanly, last at least a minimum hold time, and change only on a divider output toggle.
- Sits between the debounced key matrix and the divider. The divider's clk_out feeds back as div_tick.

Parameters:
- NUM_KEYS, 8, number of key requesters; table depth.
- DIV_W, 32, width of the divide value and table entries.
- HOLD_CYCLES, 50000, minimum clk cycles a note plays before release or switch; must be ≥1.
- KEY_W, $clog2(NUM_KEYS), key index width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_req  in  NUM_KEYS  level request per key; bit i = key i held; already synchronous to clk
- div_tick  in  1  divider clk_out fed back (same clk domain)
- cfg_we  in  1  table write strobe
- cfg_addr  in  KEY_W  table write index
- cfg_data  in  DIV_W  table write value
- div_value  out  DIV_W  divide value driven to the divider
- div_rst  out  1  holds the divider in reset when silent
- tone_active  out  1  a note is sounding
- cur_key  out  KEY_W  index of the sounding note

Behaviour:
- Reset (async, any state): state=IDLE; div_value=0; div_rst=1; tone_active=0; cur_key=0; hold counter=0; table = pkg default DEFAULT_DIV table.
- Arbitration: candidate = lowest set index of key_req (fixed priority, index 0 highest). It is computed combinationally and sampled only at the state transitions below.
- div_tick edge: div_tick differs from its 1-cycle delayed copy (either polarity).
- IDLE:
  - div_rst=1, tone_active=0.
  - If key_req≠0: cur_key←candidate, div_value←table[candidate], go START (registered; 1 cycle key→START).
- START:
  - div_rst←0, tone_active←1, hold counter←HOLD_CYCLES−1, go PLAY.
  - Divider is released 2 cycles after key_req first seen.
- PLAY:
  - Hold counter decrements to 0 and saturates there.
  - While counter≠0, all key changes are ignored (minimum note time).
  - When counter==0:
    - key_req==0 → IDLE; div_rst←1 next cycle.
    - key_req≠0 and candidate≠cur_key → SWITCH. This covers release of cur_key, or a higher-priority key pressed while cur_key is held.
    - Otherwise stay in PLAY.
- SWITCH:
  - Divider keeps running with the old div_value.
  - On a div_tick edge: cur_key←current candidate (re-sampled, not the one latched at entry), div_value←table[candidate], counter←HOLD_CYCLES−1, go PLAY.
  - If key_req becomes 0 before the edge → IDLE.
  - If candidate returns to cur_key before the edge → PLAY with no reload.
- Table writes: take effect in the table on the next cycle. div_value changes only on a load (IDLE→START or the SWITCH edge). A write to the sounding key does not retune until that key is reloaded.
- Write/load collision: a write and a load of the same index in the same cycle load the OLD value.
- HOLD_CYCLES=1: PLAY may exit the cycle after START.
- Divider contract: div_value is never changed while div_rst=0 except on a div_tick edge.

Optional Feature:
- Macro: TONE_SCHED_OCTAVE_EN.
- Defined:
  - Adds input oct_up[1:0].
  - Every load uses div_value = table[candidate] >> oct_up, with oct_up sampled at the load cycle.
  - An oct_up change while in PLAY with counter==0 and the same key held enters SWITCH as a retune to the same key.
- Undefined: the port is absent and there is no shift.

Decomposition:
- Package tone_sched_pkg: state enum (IDLE, START, PLAY, SWITCH), DEFAULT_DIV constant array (NUM_KEYS×DIV_W, note divides for a 50 MHz clk), and the lowest-set-bit priority function.
- One sub-module, tone_sched_prio_enc (NUM_KEYS→KEY_W plus a valid bit). The table stays in the top as a register array.

Test Plan:
- Reset mid-PLAY with key 3 held → next cycle: div_rst=1, tone_active=0, div_value=0, cur_key=0. After release of reset, key 3 still held → START after 1 cycle.
- HOLD_CYCLES=10, key_req=0x04 for 3 cycles then 0 → note plays; div_rst returns to 1 exactly 10 cycles after START plus 1; early release is ignored.
- Key 5 held, then key 1 pressed after hold expiry → SWITCH. div_value changes to table[1] on the first div_tick edge and not before; cur_key=1.
- In SWITCH, release all keys before the tick edge → IDLE, div_rst=1, div_value unchanged.
- cfg_we writes 1234 to index 2 while key 2 sounds → div_value unchanged. Release key 2, re-press after IDLE → div_value=1234.
- With TONE_SCHED_OCTAVE_EN, table[0]=1000 and oct_up=2 → loaded div_value=250.
